rc_chan_capture: RTL and testbench

- Parametrised successor to the radio front end: measures N RC-receiver PWM channels in parallel and converts each pulse width to a signed, centred, dead-zoned command value.
- Adds per-channel range validation, failsafe timeout, polarity inversion and runtime channel routing.
- Sits between the i_channels pads and the command logic feeding the motor controllers.
- All configuration inputs come from regbank outputs and are quasi-static.

---
 rtl/rc_chan_capture_pkg.sv | 10 +
 rtl/rc_chan_capture_meas.sv | 123 ++++++++++++
 rtl/rc_chan_capture.sv | 72 +++++++
 tb/tb_rc_chan_capture.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rc_chan_capture_pkg.sv
// rc_chan_pkg: shared channel-state enum, value type and default radio calibration
package rc_chan_pkg;
  typedef enum logic {IDLE, HIGH} chan_state_e;
  localparam int RC_RES = 12;
  typedef logic signed [RC_RES:0] rc_value_t;
  localparam logic [RC_RES-1:0] RC_CENTER_DEF = 12'd1500;
  localparam logic [RC_RES-1:0] RC_MIN_DEF = 12'd900;
  localparam logic [RC_RES-1:0] RC_MAX_DEF = 12'd2100;
  localparam logic [RC_RES-1:0] RC_DZ_DEF = 12'd20;
endpackage

// File: rtl/rc_chan_capture_meas.sv
// rc_chan_meas: one RC channel - sync, edge detect, width/timeout counting and evaluation
module rc_chan_meas
  import rc_chan_pkg::*;
#(
  parameter int K_RES = 12,
  parameter int K_TIMEOUT = 50000,
  parameter int K_TOWIDTH = $clog2(K_TIMEOUT + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pwm,
  input  logic             i_tick,
  input  logic             i_enable,
  input  logic [K_RES-1:0] i_center,
  input  logic [K_RES-1:0] i_min,
  input  logic [K_RES-1:0] i_max,
  input  logic [K_RES-1:0] i_deadzone,
  input  logic             i_polarity,
  output logic [K_RES:0]   o_value,
  output logic             o_update,
  output logic             o_failsafe,
  output logic             o_reject
);
  localparam logic [K_RES-1:0] W_SAT = '1;
  localparam logic [K_TOWIDTH-1:0] TO_END = K_TOWIDTH'(K_TIMEOUT);
  logic [1:0] sync_q;
  logic prev_q, rise_q, fall_q;
  chan_state_e state_q, state_d;
  logic [K_RES-1:0] width_q, width_d, w_nx;
  logic [K_TOWIDTH-1:0] tcnt_q, tcnt_d, t_nx;
  logic [K_RES:0] value_q, value_d, mag;
  logic signed [K_RES:0] pos, dzv, cmd;
  logic fs_q, fs_d, upd_q, upd_d, rej_q, rej_d, ok;
  // Sync and edge registers reset high so a line already high after reset or
  // a falling edge without a seen rising edge never starts a measurement.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_pwm};
      prev_q <= sync_q[1];
      rise_q <= sync_q[1] & ~prev_q;
      fall_q <= ~sync_q[1] & prev_q;
    end
  end
  // Evaluation datapath: the width includes this cycle's tick so a pulse of N ticks reads N
  always_comb begin
    w_nx = (i_tick && width_q != W_SAT) ? width_q + 1'b1 : width_q;
    t_nx = (i_tick && tcnt_q != TO_END) ? tcnt_q + 1'b1 : tcnt_q;
    ok = w_nx >= i_min && w_nx <= i_max && w_nx != W_SAT;
    pos = $signed({1'b0, w_nx}) - $signed({1'b0, i_center});
    mag = pos[K_RES] ? -pos : pos;
    dzv = (mag <= {1'b0, i_deadzone}) ? '0 : pos;
    cmd = i_polarity ? -dzv : dzv;
  end
  // Channel FSM and state updates; an accept overrides a same-cycle timeout
  always_comb begin
    state_d = state_q;
    width_d = width_q;
    tcnt_d = t_nx;
    value_d = value_q;
    fs_d = fs_q;
    upd_d = 1'b0;
    rej_d = 1'b0;
    if (t_nx == TO_END) begin
      fs_d = 1'b1;
      value_d = '0;
    end
    if (state_q == IDLE && rise_q) begin
      state_d = HIGH;
      width_d = '0;
    end
    if (state_q == HIGH) begin
      width_d = w_nx;
      if (fall_q) begin
        state_d = IDLE;
        rej_d = ~ok;
        if (ok) begin
          value_d = cmd;
          tcnt_d = '0;
          fs_d = 1'b0;
          upd_d = 1'b1;
        end
      end
    end
    if (!i_enable) begin
      state_d = IDLE;
      width_d = '0;
      tcnt_d = '0;
      fs_d = 1'b1;
      value_d = '0;
      upd_d = 1'b0;
      rej_d = 1'b0;
    end
  end
  // Channel state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      width_q <= '0;
      tcnt_q <= '0;
      value_q <= '0;
      fs_q <= 1'b1;
      upd_q <= 1'b0;
      rej_q <= 1'b0;
    end else begin
      state_q <= state_d;
      width_q <= width_d;
      tcnt_q <= tcnt_d;
      value_q <= value_d;
      fs_q <= fs_d;
      upd_q <= upd_d;
      rej_q <= rej_d;
    end
  end
  assign o_value = value_q;
  assign o_update = upd_q;
  assign o_failsafe = fs_q;
  assign o_reject = rej_q;
endmodule

// File: rtl/rc_chan_capture.sv
// rc_chan_capture: N-channel RC PWM capture with shared prescaler and output routing
module rc_chan_capture
  import rc_chan_pkg::*;
#(
  parameter int K_NCHAN = 4,
  parameter int K_RES = RC_RES,
  parameter int K_PRESCALE = 50,
  parameter int K_TIMEOUT = 50000,
  parameter int K_TOWIDTH = $clog2(K_TIMEOUT + 1),
  parameter int K_RW = (K_NCHAN > 1) ? $clog2(K_NCHAN) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [K_NCHAN-1:0]           i_channels,
  input  logic                         i_enable,
  input  logic [K_RES-1:0]             i_center,
  input  logic [K_RES-1:0]             i_min,
  input  logic [K_RES-1:0]             i_max,
  input  logic [K_RES-1:0]             i_deadzone,
  input  logic [K_NCHAN-1:0]           i_polarity,
  input  logic [K_NCHAN*K_RW-1:0]      i_route,
  output logic [K_NCHAN*(K_RES+1)-1:0] o_value,
  output logic [K_NCHAN-1:0]           o_update,
  output logic [K_NCHAN-1:0]           o_failsafe,
  output logic [K_NCHAN-1:0]           o_reject
);
  localparam int PW = (K_PRESCALE > 1) ? $clog2(K_PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(K_PRESCALE - 1);
  logic [PW-1:0] pre_q, pre_d;
  logic tick;
  logic [K_RES:0] val_w [K_NCHAN];
  logic [K_NCHAN-1:0] upd_w, fs_w;
  // Prescaler wrap produces the shared measurement tick
  always_comb begin
    tick = pre_q == PRE_LAST;
    pre_d = tick ? '0 : pre_q + 1'b1;
  end
  // Prescaler register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) pre_q <= '0;
    else pre_q <= pre_d;
  end
  for (genvar c = 0; c < K_NCHAN; c++) begin : g_chan
    rc_chan_meas #(
      .K_RES(K_RES),
      .K_TIMEOUT(K_TIMEOUT),
      .K_TOWIDTH(K_TOWIDTH)
    ) u_meas (
      .i_clk(i_clk),
      .i_rst_n(i_rst_n),
      .i_pwm(i_channels[c]),
      .i_tick(tick),
      .i_enable(i_enable),
      .i_center(i_center),
      .i_min(i_min),
      .i_max(i_max),
      .i_deadzone(i_deadzone),
      .i_polarity(i_polarity[c]),
      .o_value(val_w[c]),
      .o_update(upd_w[c]),
      .o_failsafe(fs_w[c]),
      .o_reject(o_reject[c])
    );
  end
  for (genvar r = 0; r < K_NCHAN; r++) begin : g_route
    logic [K_RW-1:0] sel;
    assign sel = i_route[r*K_RW +: K_RW];
    assign o_value[r*(K_RES+1) +: K_RES+1] = val_w[sel];
    assign o_update[r] = upd_w[sel];
    assign o_failsafe[r] = fs_w[sel];
  end
endmodule

// File: tb/tb_rc_chan_capture.sv
// tb_rc_chan_capture: directed plus randomized pulses checked against a pulse-level model
module tb_rc_chan_capture;
  import rc_chan_pkg::*;
  localparam int N = 4, R = 12, VW = R + 1, RW = 2, TO = 6000;
  logic clk = 1'b0, rst_n = 1'b1, en = 1'b0;
  logic [N-1:0] pwm = '0, pol = '0, upd, fs, rej;
  logic [R-1:0] center = RC_CENTER_DEF, mn = RC_MIN_DEF, mx = RC_MAX_DEF, dz = RC_DZ_DEF;
  logic [N*RW-1:0] route;
  logic [N*VW-1:0] value;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int st_val[N], acc_cyc[N], rt[N];
  bit armed[N];

  rc_chan_capture #(.K_NCHAN(N), .K_RES(R), .K_PRESCALE(1), .K_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_channels(pwm), .i_enable(en),
    .i_center(center), .i_min(mn), .i_max(mx), .i_deadzone(dz),
    .i_polarity(pol), .i_route(route), .o_value(value), .o_update(upd),
    .o_failsafe(fs), .o_reject(rej));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cmd_of(input int w, input bit p);
    int d;
    d = w - int'(center);
    if (d <= int'(dz) && d >= -int'(dz)) d = 0;
    return p ? -d : d;
  endfunction

  function automatic bit accepted(input int w);
    return w >= int'(mn) && w <= int'(mx) && w < (1 << R) - 1;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_route(input int a, input int b, input int c, input int d);
    rt[0] = a; rt[1] = b; rt[2] = c; rt[3] = d;
    for (int i = 0; i < N; i++) route[i*RW +: RW] = RW'(rt[i]);
  endtask

  task automatic disarm();
    for (int i = 0; i < N; i++) armed[i] = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [N-1:0] eupd, input logic [N-1:0] erej);
    for (int i = 0; i < N; i++) begin
      int p;
      bit efs;
      p = rt[i];
      efs = !armed[p] || (cyc - acc_cyc[p] >= TO);
      chk($sformatf("%s_val%0d", tag, i), $signed(value[i*VW +: VW]), efs ? 0 : st_val[p]);
      chk($sformatf("%s_fs%0d", tag, i), {31'b0, fs[i]}, int'(efs));
    end
    chk({tag, "_upd"}, {28'b0, upd}, int'(eupd));
    chk({tag, "_rej"}, {28'b0, rej}, int'(erej));
  endtask

  task automatic pulse(input int ch, input int w);
    logic [N-1:0] eu, er;
    bit a;
    @(negedge clk);
    pwm[ch] = 1'b1;
    repeat (w) @(negedge clk);
    pwm[ch] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk($sformatf("early_c%0d", ch), {24'b0, upd, rej}, 0);
    end
    @(negedge clk);
    a = accepted(w);
    eu = '0;
    er = '0;
    if (a) begin
      st_val[ch] = cmd_of(w, pol[ch]);
      armed[ch] = 1'b1;
      acc_cyc[ch] = cyc;
    end else er[ch] = 1'b1;
    for (int i = 0; i < N; i++) if (a && rt[i] == ch) eu[i] = 1'b1;
    check_all($sformatf("pulse_c%0d_w%0d", ch, w), eu, er);
    @(negedge clk);
    chk($sformatf("late_c%0d", ch), {24'b0, upd, rej}, 0);
  endtask

  initial begin
    int tgt;
    logic [N-1:0] seen;
    disarm();
    set_route(0, 1, 2, 3);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset", '0, '0);
    rst_n = 1'b1;
    en = 1'b1;
    pulse(0, 1700);
    pulse(1, 1510);
    pulse(1, 1521);
    pol[1] = 1'b1;
    pulse(1, 1700);
    pol[1] = 1'b0;
    pulse(2, 1600);
    pulse(2, 2500);
    pulse(2, 800);
    pulse(2, 5000);
    mx = '1;
    pulse(3, 4200);
    pulse(3, 4094);
    mx = RC_MAX_DEF;
    pulse(0, 1700);
    tgt = acc_cyc[0] + TO - 1;
    seen = '0;
    while (cyc < tgt) begin
      @(negedge clk);
      seen |= upd;
    end
    chk("idle_upd", {28'b0, seen}, 0);
    check_all("pre_timeout", '0, '0);
    @(negedge clk);
    check_all("timeout", '0, '0);
    pulse(0, 1600);
    set_route(0, 0, 3, 2);
    pulse(0, 1800);
    pulse(3, 1400);
    pulse(2, 1550);
    set_route(0, 1, 2, 3);
    @(negedge clk);
    pwm[0] = 1'b1;
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    disarm();
    #1 check_all("rst_mid", '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    pwm[0] = 1'b0;
    seen = '0;
    repeat (8) begin
      @(negedge clk);
      seen |= upd | rej;
    end
    chk("rst_tail", {28'b0, seen}, 0);
    check_all("rst_after", '0, '0);
    pulse(0, 1650);
    @(negedge clk);
    pwm[1] = 1'b1;
    repeat (300) @(negedge clk);
    en = 1'b0;
    disarm();
    @(negedge clk);
    check_all("disable", '0, '0);
    repeat (300) @(negedge clk);
    pwm[1] = 1'b0;
    seen = '0;
    repeat (8) begin
      @(negedge clk);
      seen |= upd | rej;
    end
    chk("dis_tail", {28'b0, seen}, 0);
    en = 1'b1;
    @(negedge clk);
    check_all("reenable", '0, '0);
    pulse(1, 1700);
    repeat (8) begin
      pol = N'($urandom);
      dz = R'($urandom_range(0, 60));
      center = R'($urandom_range(1400, 1600));
      set_route($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      pulse($urandom_range(0, 3), $urandom_range(800, 2200));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
